// File: rtl/io_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : io_input_debouncer
// Purpose  : Conditions raw board keys and slide switches before they reach
//            the memory-mapped IO read registers. Every input passes through
//            a two-flop synchroniser and a per-bit stability filter, so only
//            levels held for DEBOUNCE_CYCLES synchronised cycles are
//            forwarded. Key presses additionally set sticky event flags that
//            software acknowledges with a one-cycle clear pulse.
// Ports    :
//   clk            - system clock, rising-edge active
//   reset          - synchronous, active-high reset
//   keysRaw        - raw key pins, active-low, asynchronous to clk
//   switchesRaw    - raw switch pins, active-high, asynchronous to clk
//   clearKeyEvents - per-bit acknowledge, 1 clears the matching event flag
//   keysStable     - debounced key state, active-high (1 = pressed)
//   switchesStable - debounced switch state
//   keyEvents      - sticky press-event flags
//   eventPending   - OR of keyEvents
// Revision : 1.0 - initial release
// ============================================================================
module io_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_KEYS        = 4,
  parameter int NUM_SWITCHES    = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_KEYS-1:0]     keysRaw,
  input  logic [NUM_SWITCHES-1:0] switchesRaw,
  input  logic [NUM_KEYS-1:0]     clearKeyEvents,
  output logic [NUM_KEYS-1:0]     keysStable,
  output logic [NUM_SWITCHES-1:0] switchesStable,
  output logic [NUM_KEYS-1:0]     keyEvents,
  output logic                    eventPending
);

  localparam int NUM_INPUTS = NUM_KEYS + NUM_SWITCHES;
  localparam int CNT_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Two-flop synchronisers. Key flops idle high (key released) so that
  // leaving reset never looks like a press.
  // --------------------------------------------------------------------------
  logic [NUM_KEYS-1:0]     key_sync1;
  logic [NUM_KEYS-1:0]     key_sync2;
  logic [NUM_SWITCHES-1:0] sw_sync1;
  logic [NUM_SWITCHES-1:0] sw_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync1 <= '1;
      key_sync2 <= '1;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
    end else begin
      key_sync1 <= keysRaw;
      key_sync2 <= key_sync1;
      sw_sync1  <= switchesRaw;
      sw_sync2  <= sw_sync1;
    end
  end

  // Unified active-high view of all inputs: keys in the low bits, switches
  // above them. Keys are inverted here so every filter sees the same polarity.
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] stable_cur;
  logic [NUM_INPUTS-1:0] stable_next;

  assign level = {sw_sync2, ~key_sync2};

  // --------------------------------------------------------------------------
  // Per-input stability filter. Each bit owns its own counter and stable
  // flop; the count only advances while the synchronised level disagrees
  // with the accepted level, and any agreement restarts it from zero.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_filter
      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;
      logic             q;
      logic             q_d;

      always_comb begin
        count_d = count_q;
        q_d     = q;
        if (level[i] == q) begin
          count_d = '0;
        end else if (count_q == CNT_MAX) begin
          q_d     = level[i];
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          count_q <= '0;
          q       <= 1'b0;
        end else begin
          count_q <= count_d;
          q       <= q_d;
        end
      end

      assign stable_cur[i]  = q;
      assign stable_next[i] = q_d;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sticky key events. A rise is detected from the filter's next state so the
  // flag sets on the same edge keysStable goes high. Set has priority over an
  // acknowledge arriving on that edge, so a press is never lost.
  // --------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_rise;
  logic [NUM_KEYS-1:0] events_q;

  assign key_rise = stable_next[NUM_KEYS-1:0] & ~stable_cur[NUM_KEYS-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      events_q <= '0;
    end else begin
      events_q <= key_rise | (events_q & ~clearKeyEvents);
    end
  end

  assign keysStable     = stable_cur[NUM_KEYS-1:0];
  assign switchesStable = stable_cur[NUM_INPUTS-1:NUM_KEYS];
  assign keyEvents      = events_q;
  assign eventPending   = |events_q;

endmodule
`default_nettype wire

// File: tb/tb_io_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_input_debouncer
// Purpose  : Directed self-checking bench for io_input_debouncer with a
//            4-cycle debounce window. Inputs change 1 ns after a rising edge;
//            outputs are observed 1 ns after the following rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_input_debouncer;

  localparam int D  = 4;
  localparam int NK = 4;
  localparam int NS = 10;

  logic          clk;
  logic          reset;
  logic [NK-1:0] keysRaw;
  logic [NS-1:0] switchesRaw;
  logic [NK-1:0] clearKeyEvents;
  logic [NK-1:0] keysStable;
  logic [NS-1:0] switchesStable;
  logic [NK-1:0] keyEvents;
  logic          eventPending;

  int total;
  int bad;

  io_input_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .NUM_KEYS(NK),
    .NUM_SWITCHES(NS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keysRaw(keysRaw),
    .switchesRaw(switchesRaw),
    .clearKeyEvents(clearKeyEvents),
    .keysStable(keysStable),
    .switchesStable(switchesStable),
    .keyEvents(keyEvents),
    .eventPending(eventPending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every output at once against hand-derived values.
  task automatic expect_all(input string tag, input logic [NK-1:0] ks, input logic [NS-1:0] ss,
                            input logic [NK-1:0] ke, input logic ep);
    check(tag, {13'd0, keysStable, switchesStable, keyEvents, eventPending},
               {13'd0, ks, ss, ke, ep});
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    keysRaw        = 4'b1111;
    switchesRaw    = '0;
    clearKeyEvents = '0;

    // Reset state
    repeat (3) tick();
    expect_all("reset_state", 4'b0000, 10'h000, 4'b0000, 1'b0);

    // Idle after reset: nothing moves for 20 cycles
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      expect_all("idle", 4'b0000, 10'h000, 4'b0000, 1'b0);
    end

    // Key 0 press held: accepted on edge 6 together with its event
    keysRaw = 4'b1110;
    for (int e = 1; e <= 5; e++) begin
      tick();
      expect_all("k0_press_wait", 4'b0000, 10'h000, 4'b0000, 1'b0);
    end
    tick();
    expect_all("k0_press_edge6", 4'b0001, 10'h000, 4'b0001, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_all("k0_held", 4'b0001, 10'h000, 4'b0001, 1'b1);
    end

    // Release: stable drops on edge 6, no new event, flag stays
    keysRaw = 4'b1111;
    for (int e = 1; e <= 5; e++) begin
      tick();
      expect_all("k0_release_wait", 4'b0001, 10'h000, 4'b0001, 1'b1);
    end
    tick();
    expect_all("k0_release_edge6", 4'b0000, 10'h000, 4'b0001, 1'b1);

    // Switch 3 bounce: 3 high, 1 low, then steady high
    switchesRaw = 10'h008;
    repeat (3) begin
      tick();
      expect_all("sw3_bounce_hi", 4'b0000, 10'h000, 4'b0001, 1'b1);
    end
    switchesRaw = 10'h000;
    tick();
    expect_all("sw3_bounce_lo", 4'b0000, 10'h000, 4'b0001, 1'b1);
    switchesRaw = 10'h008;
    for (int e = 1; e <= 5; e++) begin
      tick();
      expect_all("sw3_steady_wait", 4'b0000, 10'h000, 4'b0001, 1'b1);
    end
    tick();
    expect_all("sw3_steady_edge6", 4'b0000, 10'h008, 4'b0001, 1'b1);

    // Key 1 press gives keyEvents = 0011
    keysRaw = 4'b1101;
    for (int e = 1; e <= 5; e++) begin
      tick();
      expect_all("k1_press_wait", 4'b0000, 10'h008, 4'b0001, 1'b1);
    end
    tick();
    expect_all("k1_press_edge6", 4'b0010, 10'h008, 4'b0011, 1'b1);

    // Acknowledge bit 0, then bit 1
    clearKeyEvents = 4'b0001;
    tick();
    clearKeyEvents = 4'b0000;
    expect_all("clear_bit0", 4'b0010, 10'h008, 4'b0010, 1'b1);
    tick();
    expect_all("clear_bit0_hold", 4'b0010, 10'h008, 4'b0010, 1'b1);
    clearKeyEvents = 4'b0010;
    tick();
    clearKeyEvents = 4'b0000;
    expect_all("clear_bit1", 4'b0010, 10'h008, 4'b0000, 1'b0);

    // Key 2 press with an acknowledge on the very edge it is accepted
    keysRaw = 4'b1001;
    for (int e = 1; e <= 5; e++) begin
      tick();
      expect_all("k2_press_wait", 4'b0010, 10'h008, 4'b0000, 1'b0);
    end
    clearKeyEvents = 4'b0100;
    tick();
    clearKeyEvents = 4'b0000;
    expect_all("k2_set_wins", 4'b0110, 10'h008, 4'b0100, 1'b1);
    tick();
    expect_all("k2_set_kept", 4'b0110, 10'h008, 4'b0100, 1'b1);

    // Release all keys and clear all flags
    keysRaw = 4'b1111;
    repeat (6) tick();
    expect_all("all_released", 4'b0000, 10'h008, 4'b0100, 1'b1);
    clearKeyEvents = 4'b1111;
    tick();
    clearKeyEvents = 4'b0000;
    expect_all("clear_all", 4'b0000, 10'h008, 4'b0000, 1'b0);

    // Key 1 low, reset mid-count at cycle 3 (with a clear asserted too)
    keysRaw = 4'b1101;
    repeat (2) begin
      tick();
      expect_all("k1_pre_reset", 4'b0000, 10'h008, 4'b0000, 1'b0);
    end
    reset          = 1'b1;
    clearKeyEvents = 4'b1111;
    tick();
    reset          = 1'b0;
    clearKeyEvents = 4'b0000;
    expect_all("mid_count_reset", 4'b0000, 10'h000, 4'b0000, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      expect_all("requalify_wait", 4'b0000, 10'h000, 4'b0000, 1'b0);
    end
    tick();
    expect_all("requalify_edge6", 4'b0010, 10'h008, 4'b0010, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      expect_all("requalify_held", 4'b0010, 10'h008, 4'b0010, 1'b1);
    end
    clearKeyEvents = 4'b0010;
    tick();
    clearKeyEvents = 4'b0000;
    expect_all("requalify_clear", 4'b0010, 10'h008, 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_all("no_duplicate", 4'b0010, 10'h008, 4'b0000, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
